// File: rtl/serial_subtract_ctrl.sv
// Bit-serial N-bit subtractor sequencer: drives an external single-bit
// full-subtractor cell LSB first and assembles {bout, diff} = a - b - bin.
module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             fs_x,
    output logic             fs_y,
    output logic             fs_bin,
    input  logic             fs_diff,
    input  logic             fs_bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            diff_q   <= '0;
            brw_q    <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            diff_q   <= diff_d;
            brw_q    <= brw_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        diff_d   = diff_q;
        brw_d    = brw_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    res_sh_d = {fs_diff, res_sh_q[WIDTH-1:1]};
                    brw_d    = fs_bout;
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_DONE;
                        diff_d  = {fs_diff, res_sh_q[WIDTH-1:1]};
                        bout_d  = fs_bout;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign bout   = bout_q;
    assign fs_x   = busy & a_sh_q[0];
    assign fs_y   = busy & b_sh_q[0];
    assign fs_bin = busy & brw_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Self-checking bench for serial_subtract_ctrl: WIDTH=8 directed/table runs
// and an exhaustive WIDTH=4 sweep, each DUT wired to a behavioural cell.
module tb_serial_subtract_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // WIDTH=8 instance
    logic       start8, abort8, bin8;
    logic [7:0] a8, b8, diff8;
    logic       ready8, busy8, done8, bout8;
    logic       fs_x8, fs_y8, fs_bin8, fs_diff8, fs_bout8;
    logic       force_bout0;

    // WIDTH=4 instance
    logic       start4, abort4, bin4;
    logic [3:0] a4, b4, diff4;
    logic       ready4, busy4, done4, bout4;
    logic       fs_x4, fs_y4, fs_bin4, fs_diff4, fs_bout4;

    serial_subtract_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
        .a(a8), .b(b8), .bin(bin8),
        .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8),
        .fs_x(fs_x8), .fs_y(fs_y8), .fs_bin(fs_bin8),
        .fs_diff(fs_diff8), .fs_bout(fs_bout8)
    );

    serial_subtract_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .a(a4), .b(b4), .bin(bin4),
        .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4),
        .fs_x(fs_x4), .fs_y(fs_y4), .fs_bin(fs_bin4),
        .fs_diff(fs_diff4), .fs_bout(fs_bout4)
    );

    // Behavioural full-subtractor cells
    always_comb begin
        fs_diff8 = fs_x8 ^ fs_y8 ^ fs_bin8;
        fs_bout8 = force_bout0 ? 1'b0 : ((~fs_x8 & fs_y8) | (~(fs_x8 ^ fs_y8) & fs_bin8));
        fs_diff4 = fs_x4 ^ fs_y4 ^ fs_bin4;
        fs_bout4 = (~fs_x4 & fs_y4) | (~(fs_x4 ^ fs_y4) & fs_bin4);
    end

    int dcnt8 = 0;
    int dcnt4 = 0;
    always @(negedge clk) begin
        if (done8) dcnt8++;
        if (done4) dcnt4++;
    end

    logic [8:0] q8[$];
    logic [4:0] q4[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic fail_timeout(string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        int n = 0;
        while (!ready8 && n < 20) begin step(); n++; end
        if (!ready8) fail_timeout("ready8");
    endtask

    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tbb,
                           input logic tbin, input logic [8:0] exp, input string name);
        int n = 0;
        wait_ready8();
        a8 = ta; b8 = tbb; bin8 = tbin; start8 = 1'b1;
        step();
        start8 = 1'b0;
        q8.push_back(exp);
        while (!done8 && n < 14) begin step(); n++; end
        if (!done8) begin
            fail_timeout(name);
            void'(q8.pop_front());
        end else begin
            check(name, {23'd0, bout8, diff8}, {23'd0, q8.pop_front()});
            check({name, "_latency"}, n, 8);
            step();
            check({name, "_done_pulse"}, {31'd0, done8}, 0);
            check({name, "_ready_after"}, {31'd0, ready8}, 1);
        end
    endtask

    vec_t vecs[8];
    int   dbase;
    logic [7:0] fa, fb;

    initial begin
        vecs[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[1] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h37, 8'h36, 1'b1, 8'h00, 1'b0};

        rst_n = 1'b0; force_bout0 = 1'b0;
        start8 = 0; abort8 = 0; a8 = '0; b8 = '0; bin8 = 0;
        start4 = 0; abort4 = 0; a4 = '0; b4 = '0; bin4 = 0;
        step(); step(); step();
        check("rst_ready", {31'd0, ready8}, 1);
        check("rst_busy",  {31'd0, busy8}, 0);
        check("rst_done",  {31'd0, done8}, 0);
        check("rst_result", {23'd0, bout8, diff8}, 0);
        check("rst_fs", {29'd0, fs_x8, fs_y8, fs_bin8}, 0);
        rst_n = 1'b1;
        step();

        // Cycle-accurate run: 0x5A - 0x3C
        fa = 8'h5A; fb = 8'h3C;
        a8 = fa; b8 = fb; bin8 = 0; start8 = 1;
        step();
        start8 = 0;
        a8 = 8'hAA; b8 = 8'h55;
        q8.push_back(9'h01E);
        for (int unsigned c = 1; c <= 8; c++) begin
            check($sformatf("busy_c%0d", c), {31'd0, busy8}, 1);
            check($sformatf("fs_x_c%0d", c), {31'd0, fs_x8}, {31'd0, fa[c-1]});
            check($sformatf("fs_y_c%0d", c), {31'd0, fs_y8}, {31'd0, fb[c-1]});
            step();
        end
        check("c9_done", {30'd0, done8, busy8}, 2);
        check("c9_ready", {31'd0, ready8}, 0);
        check("c9_result", {23'd0, bout8, diff8}, {23'd0, q8.pop_front()});
        step();
        check("c10_ready", {30'd0, ready8, done8}, 2);

        for (int unsigned i = 0; i < 8; i++)
            run_op8(vecs[i].a, vecs[i].b, vecs[i].bin, {vecs[i].bout, vecs[i].diff},
                    $sformatf("vec%0d", i));

        // Start while busy is ignored
        wait_ready8();
        dbase = dcnt8;
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 0; start8 = 1;
        step();
        start8 = 0;
        q8.push_back(9'h01E);
        step(); step(); step();
        a8 = 8'hFF; b8 = 8'h00; start8 = 1;
        step();
        start8 = 0;
        step(); step(); step(); step();
        check("ign_done_c9", {31'd0, done8}, 1);
        check("ign_result", {23'd0, bout8, diff8}, {23'd0, q8.pop_front()});
        step(); step(); step(); step();
        check("ign_no_queue", {31'd0, busy8}, 0);
        check("ign_done_count", dcnt8 - dbase, 1);

        // Abort in cycle 5 of 0x80 - 0x01
        dbase = dcnt8;
        a8 = 8'h80; b8 = 8'h01; bin8 = 0; start8 = 1;
        step();
        start8 = 0;
        step(); step(); step(); step();
        check("abort_c5_busy", {31'd0, busy8}, 1);
        abort8 = 1;
        step();
        abort8 = 0;
        check("abort_c6_ready", {31'd0, ready8}, 1);
        check("abort_c6_busy_done", {30'd0, busy8, done8}, 0);
        check("abort_keep_result", {23'd0, bout8, diff8}, 9'h01E);
        for (int i = 0; i < 10; i++) step();
        check("abort_no_done", dcnt8 - dbase, 0);

        // start+abort together in IDLE: abort wins
        abort8 = 1; start8 = 1; a8 = 8'h01; b8 = 8'h02;
        step();
        abort8 = 0; start8 = 0;
        check("abort_start_idle", {30'd0, ready8, busy8}, 2);

        // Reset in cycle 3 of a run
        dbase = dcnt8;
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 0; start8 = 1;
        step();
        start8 = 0;
        step(); step();
        rst_n = 0;
        step();
        rst_n = 1;
        check("midrst_ready", {31'd0, ready8}, 1);
        check("midrst_result", {23'd0, bout8, diff8}, 0);
        check("midrst_done_fs", {28'd0, done8, fs_x8, fs_y8, fs_bin8}, 0);
        for (int i = 0; i < 12; i++) step();
        check("midrst_no_done", dcnt8 - dbase, 0);
        run_op8(8'h02, 8'h03, 1'b0, 9'h1FF, "after_rst");

        // Cell with a stuck-low borrow output
        force_bout0 = 1'b1;
        run_op8(8'h00, 8'h01, 1'b0, 9'h001, "forced_bout0");
        force_bout0 = 1'b0;

        // Exhaustive WIDTH=4, restarting as soon as ready returns
        dbase = dcnt4;
        for (int unsigned ia = 0; ia < 16; ia++) begin
            for (int unsigned ib = 0; ib < 16; ib++) begin
                for (int unsigned ibin = 0; ibin < 2; ibin++) begin
                    int n = 0;
                    while (!ready4 && n < 10) begin step(); n++; end
                    if (!ready4) fail_timeout("ready4");
                    a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ibin); start4 = 1;
                    step();
                    start4 = 0;
                    q4.push_back(5'(ia) - 5'(ib) - 5'(ibin));
                    n = 0;
                    while (!done4 && n < 10) begin step(); n++; end
                    if (!done4) begin
                        fail_timeout("w4_done");
                        void'(q4.pop_front());
                    end else begin
                        check($sformatf("w4_%0h_%0h_%0d", ia, ib, ibin),
                              {27'd0, bout4, diff4}, {27'd0, q4.pop_front()});
                    end
                    step();
                end
            end
        end
        step();
        check("w4_done_count", dcnt4 - dbase, 512);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_subtract_ctrl.md
Name: serial_subtract_ctrl

Overview:
- Bit-serial sequencer that computes an N-bit subtraction (a - b - bin) with one shared single-bit full-subtractor cell, LSB first.
- Owns the operand shift registers, the borrow flop and the bit counter. Drives the cell inputs and captures the cell outputs every cycle.
- Sits between the multiplier datapath's partial-product correction stage and the external full-subtractor cell. The cell itself stays purely combinational and outside this block.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; accepted only when ready=1
- abort  in  1  synchronous cancel of a running operation
- a  in  WIDTH  minuend, sampled on accepted start
- b  in  WIDTH  subtrahend, sampled on accepted start
- bin  in  1  initial borrow-in, sampled on accepted start
- ready  out  1  high in IDLE only
- busy  out  1  high in RUN only
- done  out  1  one-cycle pulse, result valid
- diff  out  WIDTH  result register
- bout  out  1  final borrow-out register
- fs_x  out  1  to cell minuend bit
- fs_y  out  1  to cell subtrahend bit
- fs_bin  out  1  to cell borrow-in
- fs_diff  in  1  from cell: x^y^bin
- fs_bout  in  1  from cell: (~x&y)|(~(x^y)&bin)

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-low, named rst_n; clock named clk.
- Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, fs_x=fs_y=fs_bin=0, counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - a_sh<=a, b_sh<=b, brw<=bin, cnt<=0.
  - diff and bout keep their previous values until this operation completes.
- RUN, each cycle:
  - fs_x=a_sh[0], fs_y=b_sh[0], fs_bin=brw, driven combinationally from registers.
  - On the clock edge: res_sh<={fs_diff,res_sh[WIDTH-1:1]}, brw<=fs_bout, a_sh/b_sh shift right by 1, cnt<=cnt+1.
  - The cell path is sampled the same cycle it is driven (single-cycle combinational cell).
- RUN -> DONE when the bit with cnt=WIDTH-1 is captured.
  - On that edge: diff<=final shifted result (including the last fs_diff), bout<=fs_bout.
- DONE:
  - done=1 for exactly one cycle; ready=0, busy=0.
  - Unconditionally -> IDLE next cycle.
- Latency: start accepted at edge 0; WIDTH RUN cycles; done high in cycle WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- fs_x/fs_y/fs_bin are 0 outside RUN.
- start while busy or in DONE is ignored: no queueing, no effect on the current result.
- abort=1 in RUN:
  - -> IDLE next edge; no done pulse.
  - diff/bout keep the last completed result; partial result is discarded.
- abort in IDLE/DONE: no effect. start and abort together in IDLE: abort wins, start not accepted.
- rst_n=0 mid-RUN: all reset values next edge; no done pulse.
- Arithmetic: {bout,diff} is the two's-complement of a-b-bin in WIDTH+1 bits. bout=1 iff a < b+bin (unsigned).
- Operand inputs are ignored outside the accepting edge; changing them during RUN has no effect.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start 1 cycle -> busy cycles 1-8, done in cycle 9, diff=0x1E, bout=0; fs_x sequence 0,1,0,1,1,0,1,0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- Exhaustive for WIDTH=4 (all a, b, bin; 512 ops, back-to-back start on each ready) -> every {bout,diff} matches a-b-bin mod 32; exactly one done per op.
- Run 0x5A-0x3C, pulse start with a=0xFF,b=0x00 in cycle 4 -> ignored, result still 0x1E/0. Assert abort in cycle 5 of a second run (0x80-0x01) -> no done, ready=1 at cycle 6, diff stays 0x1E.
- rst_n=0 in cycle 3 of a run -> next cycle ready=1, diff=0, bout=0, done never pulses. Then a fresh 0x02-0x03 -> diff=0xFF, bout=1.
- Bench cell model forced to fs_bout=0 -> exposes that bout/borrow chain come only from the cell: 0x00-0x01 yields diff=0x01, bout=0.
